// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MAX_STARVE = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle; the arbiter uses the slave view.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_arb_prio.sv
// Combinational winner selection: data wins unless fetch has been starved too long.
module arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_STARVE = DEF_MAX_STARVE,
    parameter int CNT_W      = 3
) (
    input  logic             if_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             req_valid,
    output logic             winner
);

    always_comb begin
        req_valid = if_req | d_req;
        winner    = REQ_D;
        if (if_req && (!d_req || starve_cnt == CNT_W'(MAX_STARVE))) begin
            winner = REQ_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port memory, one access in flight.
// Every grant is a two-cycle ISSUE/RESP pair; RESP re-arbitrates for back-to-back use.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_STARVE = DEF_MAX_STARVE
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    localparam int               CNT_W      = $clog2(MAX_STARVE + 2);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_STARVE);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              winner_q, winner_d;
    logic              rd_q, rd_d;
    logic              misalign_q, misalign_d;
    logic              gnt_q, gnt_d;
    logic              rvalid_q, rvalid_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              any_req;
    logic              arb_winner;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic              sel_aligned;
    logic [DATA_W-1:0] resp_data;

    arb_prio #(
        .MAX_STARVE (MAX_STARVE),
        .CNT_W      (CNT_W)
    ) u_prio (
        .if_req     (bus.if_req),
        .d_req      (bus.d_req),
        .starve_cnt (starve_q),
        .req_valid  (any_req),
        .winner     (arb_winner)
    );

    always_comb begin
        sel_addr    = (arb_winner == REQ_D) ? bus.d_addr : bus.if_addr;
        sel_we      = (arb_winner == REQ_D) && bus.d_we;
        sel_aligned = (sel_addr[1:0] == 2'b00);

        state_d     = state_q;
        starve_d    = starve_q;
        winner_d    = winner_q;
        rd_d        = rd_q;
        misalign_d  = misalign_q;
        gnt_d       = 1'b0;
        rvalid_d    = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;

        case (state_q)
            ISSUE: begin
                state_d  = RESP;
                rvalid_d = 1'b1;
            end
            default: begin
                // ARB and RESP both arbitrate, so a pending request issues without an idle cycle
                state_d = ARB;
                if (any_req) begin
                    state_d    = ISSUE;
                    winner_d   = arb_winner;
                    gnt_d      = 1'b1;
                    misalign_d = !sel_aligned;
                    rd_d       = sel_aligned && !sel_we;
                    if (sel_aligned) begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = sel_we;
                        mem_addr_d  = sel_addr;
                        mem_wdata_d = sel_we ? bus.d_wdata : '0;
                    end
                    if (arb_winner == REQ_IF) begin
                        starve_d = '0;
                    end else if (bus.if_req && starve_q != STARVE_MAX) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end
            end
        endcase

        if (!bus.if_req) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB;
            starve_q    <= '0;
            winner_q    <= REQ_IF;
            rd_q        <= 1'b0;
            misalign_q  <= 1'b0;
            gnt_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            winner_q    <= winner_d;
            rd_q        <= rd_d;
            misalign_q  <= misalign_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Read data comes straight from memory in RESP; gated so writes and errors return zero
    assign resp_data = (rvalid_q && rd_q) ? bus.mem_rdata : '0;

    assign bus.if_gnt    = gnt_q && (winner_q == REQ_IF);
    assign bus.if_rvalid = rvalid_q && (winner_q == REQ_IF);
    assign bus.if_err    = rvalid_q && misalign_q && (winner_q == REQ_IF);
    assign bus.if_rdata  = (winner_q == REQ_IF) ? resp_data : '0;

    assign bus.d_gnt     = gnt_q && (winner_q == REQ_D);
    assign bus.d_rvalid  = rvalid_q && (winner_q == REQ_D);
    assign bus.d_err     = rvalid_q && misalign_q && (winner_q == REQ_D);
    assign bus.d_rdata   = (winner_q == REQ_D) ? resp_data : '0;

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a small registered memory model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] mem [16] = '{
        32'h20080005, 32'h11110004, 32'h22220008, 32'h3333000C,
        32'hCAFE0010, 32'h55550014, 32'h66660018, 32'h7777001C,
        32'h88880020, 32'h99990024, 32'hAAAA0028, 32'hBBBB002C,
        32'hCCCC0030, 32'hDDDD0034, 32'hEEEE0038, 32'hFFFF003C
    };

    // Single-port memory: read data appears one cycle after mem_en
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr[5:2]];
        end
    end

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.if_gnt, bus.if_rvalid, bus.if_err, bus.d_gnt, bus.d_rvalid, bus.d_err, bus.mem_en, bus.mem_we} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b want 00000000", {bus.if_gnt, bus.if_rvalid, bus.if_err, bus.d_gnt, bus.d_rvalid, bus.d_err, bus.mem_en, bus.mem_we});
        end
        checks++;
        if ({bus.if_rdata, bus.d_rdata} !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_rdata: got %h %h want 0 0", bus.if_rdata, bus.d_rdata);
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_mem_bus: got %h %h want 0 0", bus.mem_addr, bus.mem_wdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0000;
        @(negedge clk);
        checks++;
        if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we} !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL fetch_issue: got gnt_if/gnt_d/en/we=%b want 1010", {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we});
        end
        checks++;
        if (bus.mem_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL fetch_addr: got %h want 00000000", bus.mem_addr);
        end
        bus.if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.if_rvalid, bus.if_err, bus.if_gnt, bus.mem_en, bus.d_rvalid} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL fetch_resp_flags: got %b want 10000", {bus.if_rvalid, bus.if_err, bus.if_gnt, bus.mem_en, bus.d_rvalid});
        end
        checks++;
        if (bus.if_rdata !== 32'h20080005) begin
            errors++;
            $display("[TB] FAIL fetch_rdata: got %h want 20080005", bus.if_rdata);
        end
        @(negedge clk);
        checks++;
        if (bus.if_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fetch_rvalid_pulse: got %b want 0", bus.if_rvalid);
        end
    endtask

    task automatic test_write();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_2004;
        bus.d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({bus.d_gnt, bus.if_gnt, bus.mem_en, bus.mem_we} !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL write_issue: got gnt_d/gnt_if/en/we=%b want 1011", {bus.d_gnt, bus.if_gnt, bus.mem_en, bus.mem_we});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== {32'h0000_2004, 32'hDEAD_BEEF}) begin
            errors++;
            $display("[TB] FAIL write_bus: got %h %h want 00002004 deadbeef", bus.mem_addr, bus.mem_wdata);
        end
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.d_rvalid, bus.d_err, bus.mem_en} !== 3'b100 || bus.d_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL write_resp: got rvalid/err/en=%b rdata=%h want 100 0", {bus.d_rvalid, bus.d_err, bus.mem_en}, bus.d_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_2002;
        @(negedge clk);
        checks++;
        if ({bus.d_gnt, bus.mem_en} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL misalign_issue: got gnt/en=%b want 10", {bus.d_gnt, bus.mem_en});
        end
        bus.d_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.d_rvalid, bus.d_err} !== 2'b11 || bus.d_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL misalign_resp: got rvalid/err=%b rdata=%h want 11 0", {bus.d_rvalid, bus.d_err}, bus.d_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic prev_en;
        int   gnt_cnt;
        int   en_cnt;
        prev_en    = 1'b0;
        gnt_cnt    = 0;
        en_cnt     = 0;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_0004;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (bus.d_gnt !== (i % 2 == 0) || (bus.mem_en && prev_en)) begin
                errors++;
                $display("[TB] FAIL b2b_cadence[%0d]: got gnt=%b en=%b prev_en=%b want gnt=%b", i, bus.d_gnt, bus.mem_en, prev_en, (i % 2 == 0));
            end
            if (i % 2 == 1) begin
                checks++;
                if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("[TB] FAIL b2b_rdata[%0d]: got rvalid=%b rdata=%h want 1 deadbeef", i, bus.d_rvalid, bus.d_rdata);
                end
            end
            gnt_cnt += int'(bus.d_gnt);
            en_cnt  += int'(bus.mem_en);
            prev_en  = bus.mem_en;
        end
        bus.d_req = 1'b0;
        checks++;
        if (gnt_cnt != 8 || en_cnt != 8) begin
            errors++;
            $display("[TB] FAIL b2b_counts: got gnt=%0d en=%0d want 8 8", gnt_cnt, en_cnt);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_starvation();
        int    gidx;
        int    last_if;
        logic  exp_if;
        gidx        = 0;
        last_if     = 0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0000;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0000_0008;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            checks++;
            if ((bus.if_gnt && bus.d_gnt) || (bus.if_rvalid && bus.d_rvalid) || ((bus.if_gnt | bus.d_gnt) !== (i % 2 == 0))) begin
                errors++;
                $display("[TB] FAIL starve_exclusive[%0d]: got gnt if/d=%b%b rvalid if/d=%b%b", i, bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid);
            end
            if (bus.if_gnt || bus.d_gnt) begin
                exp_if = (gidx % 5 == 4);
                checks++;
                if (bus.if_gnt !== exp_if) begin
                    errors++;
                    $display("[TB] FAIL starve_order[%0d]: got if_gnt=%b want %b", gidx, bus.if_gnt, exp_if);
                end
                if (bus.if_gnt) last_if = i;
                gidx++;
            end
            checks++;
            if (i - last_if > 10) begin
                errors++;
                $display("[TB] FAIL starve_fetch_wait[%0d]: got %0d cycles want <=10", i, i - last_if);
            end
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        checks++;
        if (gidx != 12) begin
            errors++;
            $display("[TB] FAIL starve_grants: got %0d want 12", gidx);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0010;
        @(negedge clk);
        checks++;
        if (bus.if_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_gnt: got %b want 1", bus.if_gnt);
        end
        @(negedge clk);
        checks++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hCAFE0010) begin
            errors++;
            $display("[TB] FAIL rstmid_resp: got rvalid=%b rdata=%h want 1 cafe0010", bus.if_rvalid, bus.if_rdata);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.if_gnt, bus.if_rvalid, bus.if_err, bus.d_gnt, bus.d_rvalid, bus.mem_en} !== 6'b0 || bus.if_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rstmid_async: got flags=%b rdata=%h want 000000 0", {bus.if_gnt, bus.if_rvalid, bus.if_err, bus.d_gnt, bus.d_rvalid, bus.mem_en}, bus.if_rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.if_gnt, bus.if_rvalid} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL rstmid_regrant: got gnt/rvalid=%b want 10", {bus.if_gnt, bus.if_rvalid});
        end
        bus.if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hCAFE0010) begin
            errors++;
            $display("[TB] FAIL rstmid_newresp: got rvalid=%b rdata=%h want 1 cafe0010", bus.if_rvalid, bus.if_rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        $display("[TB] starting mem_arbiter directed tests");
        @(negedge clk);
        test_reset();
        test_fetch();
        test_write();
        test_misaligned();
        test_back_to_back();
        test_starvation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width.
REQ-002 Parameter DATA_W, default 32, word width.
REQ-003 Parameter MAX_STARVE, default 4, consecutive data grants allowed while fetch waits.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 if_req / if_addr  in  1 / ADDR_W  fetch request (level, held until if_gnt) and address.
REQ-007 if_gnt / if_rvalid / if_rdata / if_err  out  1/1/DATA_W/1  fetch grant pulse, response pulse, read word, misalign flag.
REQ-008 d_req / d_we / d_addr / d_wdata  in  1/1/ADDR_W/DATA_W  data request held until d_gnt, write enable, address, write word.
REQ-009 d_gnt / d_rvalid / d_rdata / d_err  out  1/1/DATA_W/1  data grant pulse, response pulse, read word, misalign flag.
REQ-010 mem_en / mem_we / mem_addr / mem_wdata  out  1/1/ADDR_W/DATA_W  single-port memory access, all registered.
REQ-011 mem_rdata  in  DATA_W  memory read word, valid one cycle after mem_en.

Function
REQ-012 FSM states ARB, ISSUE, RESP; one transaction outstanding at most.
REQ-013 ARB: no request -> stay; any request -> latch winner, address, we, wdata; go ISSUE.
REQ-014 Priority: data beats fetch unless starve_cnt == MAX_STARVE and if_req high, then fetch wins.
REQ-015 starve_cnt increments on a data win with if_req high, clears on any fetch win or if_req low, saturates at MAX_STARVE.
REQ-016 ISSUE: winner's gnt high exactly this cycle; mem_en high with latched address/we/wdata iff addr[1:0]==0; go RESP.
REQ-017 RESP: winner's rvalid high one cycle; rdata = mem_rdata for reads, 0 for writes and errors; err = 1 iff misaligned.
REQ-018 RESP arbitrates as ARB does (pending request -> ISSUE next cycle), sustaining one access per 2 cycles; none pending -> ARB.
REQ-019 Misaligned request: no memory access, gnt and rvalid still issued per REQ-016/017.
REQ-020 Loser's request stays pending; never granted, never dropped.
REQ-021 Simultaneous if_req and d_req in ARB with starve_cnt < MAX_STARVE: data granted, fetch ISSUE follows RESP.
REQ-022 Requests deasserted before grant are a protocol violation; behaviour undefined, no checking required.
REQ-023 gnt and rvalid never asserted to both requesters in one cycle; mem_en never high outside ISSUE.

Reset
REQ-024 reset asserted: state = ARB, starve_cnt = 0, all outputs 0 (gnt, rvalid, err, rdata, mem_*) immediately, regardless of clk.
REQ-025 Reset during ISSUE or RESP aborts the transaction; no rvalid issued for it after reset release.
REQ-026 First grant possible on the first rising edge after reset deasserts.

Structure
REQ-027 Shared package holds state enum (ARB/ISSUE/RESP), requester-ID constants (REQ_IF=0, REQ_D=1) and default widths.
REQ-028 One sub-module, arb_prio, combinational winner selection from if_req, d_req, starve_cnt.
REQ-029 All memory-side outputs register-driven; no combinational path from requester inputs to mem_*.

Verification
REQ-030 if_req, if_addr=0x0000 only -> if_gnt at cycle 2, mem_en/mem_addr=0x0000 at cycle 2, if_rvalid with mem_rdata=0x20080005 at cycle 3.
REQ-031 d_req, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF -> mem_we=1 with that addr/data in ISSUE; d_rvalid, d_rdata=0, d_err=0 next cycle.
REQ-032 if_req and d_req both held continuously -> grant order D,D,D,D,IF,D,... (MAX_STARVE=4); no stall of either beyond 10 cycles.
REQ-033 d_addr=0x2002 read -> mem_en stays 0; d_gnt then d_rvalid with d_err=1, d_rdata=0.
REQ-034 reset asserted mid-cycle during RESP of a fetch -> all outputs 0 before next edge; no if_rvalid after release; held if_req regranted.
REQ-035 Back-to-back d_req stream -> d_gnt every 2 cycles, mem_en duty 50%, never two mem_en in consecutive cycles.
